fpu_issue_queue: RTL

Operand issue buffer sitting directly upstream of the `fpu` block. Accepts (command, operand A, operand B) triples from the instruction decoder over a valid/ready handshake, stores them in order in a small FIFO, and presents the head entry to the FPU over its `input_rdy`/`input_ack` handshake. This decouples decode from FPU busy periods and lets the decoder issue back-to-back operations.

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/fpu_issue_queue.sv | 90 +++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: legal command codes, the legality check and the issued-operation layout.
// The command check in fpu_issue_queue is compiled in only when FPU_ISSUE_CMD_CHECK_EN is defined.
package fpu_pkg;

  localparam int FPU_WIDTH = 32;

  localparam logic [3:0] CMD_ADD = 4'h0;
  localparam logic [3:0] CMD_SUB = 4'h1;
  localparam logic [3:0] CMD_MUL = 4'h2;
  localparam logic [3:0] CMD_DIV = 4'h3;

  typedef struct packed {
    logic [3:0]           command;
    logic [FPU_WIDTH-1:0] a;
    logic [FPU_WIDTH-1:0] b;
  } fpu_op_t;

  function automatic logic cmd_is_legal(input logic [3:0] cmd);
    logic ok;
    ok = 1'b0;
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_MUL, CMD_DIV: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: write-to-read latency 1 cycle, read data is the registered head entry.
// Backpressure: push is ignored while full and pop while empty; flush empties it at the next edge.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; count tells full from empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fpu_issue_queue.sv
// In-order operand buffer in front of the FPU: push-to-present 1 cycle, in_ready drops when full/flush/reset.
// FPU_ISSUE_CMD_CHECK_EN drops illegal commands on accept and reports them via cmd_error/err_count.
module fpu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_command,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   input_rdy,
  input  logic                   input_ack,
  output logic [3:0]             command,
  output logic [WIDTH-1:0]       data_a,
  output logic [WIDTH-1:0]       data_b,
  output logic [$clog2(DEPTH):0] count,
  output logic                   cmd_error,
  output logic [7:0]             err_count
);

  import fpu_pkg::*;

  // Same field order as fpu_op_t, with operands sized by WIDTH.
  typedef struct packed {
    logic [3:0]       command;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  op_t  wr_op;
  op_t  head;
  logic empty;
  logic full;
  logic accept;
  logic legal;
  logic push;
  logic pop;

  assign in_ready = !full && !flush && !reset;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign input_rdy = !empty;
  assign pop      = input_rdy && input_ack;
  assign wr_op    = '{command: in_command, a: in_a, b: in_b};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(op_t))
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_op),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Storage is not cleared, so the head fields are masked whenever nothing is presented.
  assign command = input_rdy ? head.command : '0;
  assign data_a  = input_rdy ? head.a       : '0;
  assign data_b  = input_rdy ? head.b       : '0;

`ifdef FPU_ISSUE_CMD_CHECK_EN
  assign legal = cmd_is_legal(in_command);

  // accept is already false during flush, so flushed drops are never counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_error <= 1'b0;
      err_count <= '0;
    end else begin
      cmd_error <= accept && !legal;
      if (accept && !legal && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
  end
`else
  assign legal     = 1'b1;
  assign cmd_error = 1'b0;
  assign err_count = '0;
`endif

endmodule
